// File: rtl/osd_mam_dii_rx_pkg.sv
// Shared definitions for the MAM DII ingress engine: header fields, FSM states, beat packing.
package osd_mam_dii_rx_pkg;

  localparam int unsigned MAM_RW        = 15;
  localparam int unsigned MAM_BURST     = 14;
  localparam int unsigned MAM_BEATS_MSB = 13;

  typedef enum logic [3:0] {
    StIdle,
    StSrc,
    StHdr,
    StAddr,
    StReq,
    StData,
    StContDest,
    StContSrc,
    StDrop
  } mam_rx_state_t;

  function automatic int unsigned flits_per_word(int unsigned dw);
    return dw / 16;
  endfunction

endpackage

// File: rtl/osd_mam_dii_rx_if.sv
// Debug-ring ingress plus memory request/write-beat signals of the MAM DII receiver.
interface osd_mam_dii_rx_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 32
);
  logic [15:0]             debug_in_data;
  logic                    debug_in_valid;
  logic                    debug_in_last;
  logic                    debug_in_ready;
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_rw;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic                    req_burst;
  logic [13:0]             req_beats;
  logic                    write_valid;
  logic [DATA_WIDTH-1:0]   write_data;
  logic [DATA_WIDTH/8-1:0] write_strb;
  logic                    write_ready;
  logic                    err;

  modport master (
    input  debug_in_data, debug_in_valid, debug_in_last, req_ready, write_ready,
    output debug_in_ready, req_valid, req_rw, req_addr, req_burst, req_beats,
    output write_valid, write_data, write_strb, err
  );

  modport slave (
    output debug_in_data, debug_in_valid, debug_in_last, req_ready, write_ready,
    input  debug_in_ready, req_valid, req_rw, req_addr, req_burst, req_beats,
    input  write_valid, write_data, write_strb, err
  );
endinterface

// File: rtl/osd_mam_word_pack.sv
// Packs 16-bit flits into a DATA_WIDTH beat, first flit in the most-significant position.
module osd_mam_word_pack import osd_mam_dii_rx_pkg::*; #(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  push_i,
  input  logic [15:0]           flit_i,
  output logic [DATA_WIDTH-1:0] beat_o,
  output logic                  complete_o
);
  localparam int unsigned Fpw = flits_per_word(DATA_WIDTH);

  logic [2:0] cnt_q, cnt_d;

  // complete_o means a push in this cycle finishes the beat on beat_o.
  assign complete_o = (cnt_q == 3'(Fpw - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (push_i) begin
      cnt_d = complete_o ? 3'd0 : cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  if (DATA_WIDTH > 16) begin : g_wide
    logic [DATA_WIDTH-17:0] acc_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)      acc_q <= '0;
      else if (clear_i) acc_q <= '0;
      else if (push_i)  acc_q <= beat_o[DATA_WIDTH-17:0];
    end
    assign beat_o = {acc_q, flit_i};
  end else begin : g_narrow
    assign beat_o = flit_i;
  end

endmodule

// File: rtl/osd_mam_dii_rx.sv
// MAM DII ingress: parses write/read packets into one memory request plus packed write beats.
module osd_mam_dii_rx import osd_mam_dii_rx_pkg::*; #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned MAX_PKT_LEN = 8
) (
  input logic              clk,
  input logic              rst,
  osd_mam_dii_rx_if.master bus
);
  localparam int unsigned StrbW     = DATA_WIDTH / 8;
  localparam int unsigned AddrFlits = ADDR_WIDTH / 16;
  localparam int unsigned LenW      = $clog2(MAX_PKT_LEN + 2);

  mam_rx_state_t state_q, state_d;
  logic                  rdy_en_q;
  logic                  rw_q, rw_d, burst_q, burst_d, drop_after_q, drop_after_d;
  logic [13:0]           beats_q, beats_d, left_q, left_d;
  logic [StrbW-1:0]      strb_q, strb_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, addr_next;
  logic [7:0]            addr_cnt_q, addr_cnt_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, beat;
  logic                  wvalid_q, wvalid_d, err_q, err_d;
  logic [LenW-1:0]       len_q, len_d;
  logic                  rdy, accept, push, beat_done, last, write_stall, pkt_start;
  logic [15:0]           flit;

  assign flit        = bus.debug_in_data;
  assign last        = bus.debug_in_last;
  assign write_stall = wvalid_q && !bus.write_ready;
  assign pkt_start   = (state_q == StIdle) || (state_q == StContDest);

  if (ADDR_WIDTH > 16) begin : g_addr_wide
    assign addr_next = {addr_q[ADDR_WIDTH-17:0], flit};
  end else begin : g_addr_narrow
    assign addr_next = flit;
  end

  // A new beat may only be loaded once the previous one has been handed off.
  always_comb begin
    rdy = 1'b1;
    unique case (state_q)
      StIdle, StData: rdy = !write_stall;
      StReq:          rdy = 1'b0;
      default:        rdy = 1'b1;
    endcase
    rdy = rdy && rdy_en_q;
  end

  assign accept = bus.debug_in_valid && rdy;
  assign push   = accept && (state_q == StData);

  osd_mam_word_pack #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_pack (
    .clk_i     (clk),
    .rst_ni    (rst),
    .clear_i   (state_q != StData),
    .push_i    (push),
    .flit_i    (flit),
    .beat_o    (beat),
    .complete_o(beat_done)
  );

  always_comb begin
    state_d      = state_q;
    rw_d         = rw_q;
    burst_d      = burst_q;
    beats_d      = beats_q;
    strb_d       = strb_q;
    addr_d       = addr_q;
    addr_cnt_d   = addr_cnt_q;
    drop_after_d = drop_after_q;
    left_d       = left_q;
    wdata_d      = wdata_q;
    wvalid_d     = wvalid_q && !bus.write_ready;
    len_d        = len_q;
    err_d        = 1'b0;

    if (accept) begin
      if (pkt_start) begin
        len_d = LenW'(1);
      end else if (len_q != LenW'(MAX_PKT_LEN + 1)) begin
        len_d = len_q + LenW'(1);
      end
      // Fires once: the counter saturates one past the limit.
      if (!pkt_start && len_q == LenW'(MAX_PKT_LEN)) err_d = 1'b1;
    end

    unique case (state_q)
      StIdle: if (accept) begin
        if (last) err_d = 1'b1;
        else      state_d = StSrc;
      end
      StSrc: if (accept) begin
        if (last) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          state_d = StHdr;
        end
      end
      StHdr: if (accept) begin
        rw_d         = flit[MAM_RW];
        burst_d      = flit[MAM_BURST];
        beats_d      = flit[MAM_BURST] ? flit[MAM_BEATS_MSB:0] : 14'd1;
        strb_d       = flit[MAM_BURST] ? '1 : flit[StrbW-1:0];
        addr_cnt_d   = '0;
        drop_after_d = 1'b0;
        if (last) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else if (flit[MAM_BURST] && flit[MAM_BEATS_MSB:0] == '0) begin
          err_d   = 1'b1;
          state_d = StDrop;
        end else begin
          state_d = StAddr;
        end
      end
      StAddr: if (accept) begin
        addr_d     = addr_next;
        addr_cnt_d = addr_cnt_q + 8'd1;
        if (addr_cnt_q == 8'(AddrFlits - 1)) begin
          if (rw_q && last) begin
            err_d   = 1'b1;
            state_d = StIdle;
          end else begin
            state_d = StReq;
            if (!rw_q && !last) begin
              err_d        = 1'b1;
              drop_after_d = 1'b1;
            end
          end
        end else if (last) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
      StReq: if (bus.req_ready) begin
        left_d  = beats_q;
        state_d = rw_q ? StData : (drop_after_q ? StDrop : StIdle);
      end
      StData: if (push) begin
        if (beat_done) begin
          wdata_d  = beat;
          wvalid_d = 1'b1;
          left_d   = left_q - 14'd1;
          if (left_q == 14'd1) begin
            state_d = last ? StIdle : StDrop;
            err_d   = err_d || !last;
          end else if (last) begin
            state_d = StContDest;
          end
        end else if (last) begin
          // Words may not span packets; the partial beat is discarded.
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
      StContDest, StContSrc: if (accept) begin
        if (last) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          state_d = (state_q == StContDest) ? StContSrc : StData;
        end
      end
      StDrop: if (accept && last) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      rdy_en_q     <= 1'b0;
      rw_q         <= 1'b0;
      burst_q      <= 1'b0;
      beats_q      <= '0;
      strb_q       <= '0;
      addr_q       <= '0;
      addr_cnt_q   <= '0;
      drop_after_q <= 1'b0;
      left_q       <= '0;
      wdata_q      <= '0;
      wvalid_q     <= 1'b0;
      len_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      rdy_en_q     <= 1'b1;
      rw_q         <= rw_d;
      burst_q      <= burst_d;
      beats_q      <= beats_d;
      strb_q       <= strb_d;
      addr_q       <= addr_d;
      addr_cnt_q   <= addr_cnt_d;
      drop_after_q <= drop_after_d;
      left_q       <= left_d;
      wdata_q      <= wdata_d;
      wvalid_q     <= wvalid_d;
      len_q        <= len_d;
      err_q        <= err_d;
    end
  end

  assign bus.debug_in_ready = rdy;
  assign bus.req_valid      = (state_q == StReq);
  assign bus.req_rw         = rw_q;
  assign bus.req_addr       = addr_q;
  assign bus.req_burst      = burst_q;
  assign bus.req_beats      = beats_q;
  assign bus.write_valid    = wvalid_q;
  assign bus.write_data     = wdata_q;
  assign bus.write_strb     = strb_q;
  assign bus.err            = err_q;

endmodule
